// File: rtl/instr_mem_loader.sv
// Byte-stream program loader for the 32-word instruction memory.
// Packs little-endian bytes into words, writes them at word-aligned addresses and stalls the CPU until done.
module instr_mem_loader #(
   parameter int DEPTH = 32,
   parameter int AW    = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [5:0]    len_i,
   input  logic          byte_valid_i,
   input  logic [7:0]    byte_i,
   output logic          byte_ready_o,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [31:0]   wr_data_o,
   output logic          cpu_hold_o,
   output logic          done_o,
   output logic [31:0]   checksum_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] DEPTH_L = 6'(DEPTH);

   state_t        state_r, state_s;
   logic [1:0]    lane_r, lane_s;
   logic [5:0]    word_idx_r, word_idx_s;
   logic [5:0]    eff_len_r, eff_len_s;
   logic [23:0]   part_r, part_s;
   logic          wr_en_r, wr_en_s;
   logic [AW-1:0] wr_addr_r, wr_addr_s;
   logic [31:0]   wr_data_r, wr_data_s;
   logic [31:0]   checksum_r, checksum_s;
   logic          byte_ready_r, byte_ready_s;
   logic          cpu_hold_r, cpu_hold_s;
   logic          done_r, done_s;
   logic [5:0]    req_len_s;
   logic [31:0]   word_s;
   logic          accept_s;

   assign req_len_s = (len_i > DEPTH_L) ? DEPTH_L : len_i;
   assign word_s    = {byte_i, part_r};
   assign accept_s  = byte_valid_i & byte_ready_r;

   // Next-state, packing and write-strobe generation
   always_comb begin
      state_s    = state_r;
      lane_s     = lane_r;
      word_idx_s = word_idx_r;
      eff_len_s  = eff_len_r;
      part_s     = part_r;
      wr_en_s    = 1'b0;
      wr_addr_s  = wr_addr_r;
      wr_data_s  = wr_data_r;
      checksum_s = checksum_r;
      case (state_r)
         IDLE, DONE: begin
            if (start_i) begin
               eff_len_s  = req_len_s;
               lane_s     = 2'd0;
               word_idx_s = 6'd0;
               part_s     = 24'd0;
               checksum_s = 32'd0;
               if (req_len_s != 6'd0) begin
                  state_s = LOAD;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = state_r;
            end
         end
         LOAD: begin
            if (accept_s) begin
               if (lane_r == 2'd3) begin
                  wr_en_s    = 1'b1;
                  wr_data_s  = word_s;
                  wr_addr_s  = AW'({word_idx_r, 2'b00});
                  checksum_s = checksum_r + word_s;
                  lane_s     = 2'd0;
                  word_idx_s = word_idx_r + 6'd1;
                  if ((word_idx_r + 6'd1) == eff_len_r) begin
                     state_s = DONE;
                  end else begin
                     state_s = LOAD;
                  end
               end else begin
                  lane_s = lane_r + 2'd1;
                  case (lane_r)
                     2'd0:    part_s[7:0]   = byte_i;
                     2'd1:    part_s[15:8]  = byte_i;
                     2'd2:    part_s[23:16] = byte_i;
                     default: part_s        = part_r;
                  endcase
               end
            end else begin
               state_s = LOAD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Status flags; done waits out the final write cycle so the CPU never sees a half-written program
   always_comb begin
      byte_ready_s = (state_s == LOAD);
      done_s       = (state_s == DONE) && (state_r != LOAD);
      cpu_hold_s   = ~done_s;
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r      <= IDLE;
         lane_r       <= 2'd0;
         word_idx_r   <= 6'd0;
         eff_len_r    <= 6'd0;
         part_r       <= 24'd0;
         wr_en_r      <= 1'b0;
         wr_addr_r    <= '0;
         wr_data_r    <= 32'd0;
         checksum_r   <= 32'd0;
         byte_ready_r <= 1'b0;
         cpu_hold_r   <= 1'b1;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         lane_r       <= lane_s;
         word_idx_r   <= word_idx_s;
         eff_len_r    <= eff_len_s;
         part_r       <= part_s;
         wr_en_r      <= wr_en_s;
         wr_addr_r    <= wr_addr_s;
         wr_data_r    <= wr_data_s;
         checksum_r   <= checksum_s;
         byte_ready_r <= byte_ready_s;
         cpu_hold_r   <= cpu_hold_s;
         done_r       <= done_s;
      end
   end

   assign byte_ready_o = byte_ready_r;
   assign wr_en_o      = wr_en_r;
   assign wr_addr_o    = wr_addr_r;
   assign wr_data_o    = wr_data_r;
   assign cpu_hold_o   = cpu_hold_r;
   assign done_o       = done_r;
   assign checksum_o   = checksum_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes come from a word-level model of each load.
module tb_instr_mem_loader;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [5:0]  len_i;
   logic        byte_valid_i;
   logic [7:0]  byte_i;
   logic        byte_ready_o;
   logic        wr_en_o;
   logic [31:0] wr_addr_o;
   logic [31:0] wr_data_o;
   logic        cpu_hold_o;
   logic        done_o;
   logic [31:0] checksum_o;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          writes = 0;
   logic        prev_wr = 1'b0;
   logic [31:0] exp_sum;

   always #5 clk_i = ~clk_i;

   instr_mem_loader #(.DEPTH(32), .AW(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
      .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .cpu_hold_o(cpu_hold_o), .done_o(done_o), .checksum_o(checksum_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe is matched against the next expected write
   always @(negedge clk_i) begin
      if (wr_en_o) begin
         writes++;
         check("wr_pulse_width", 32'(prev_wr), 32'd0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write", wr_addr_o, wr_data_o);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", wr_addr_o, e.addr);
            check("wr_data", wr_data_o, e.data);
         end
      end
      prev_wr = wr_en_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int eff_of(input int len);
      return (len > 32) ? 32 : len;
   endfunction

   // Model: word w = bytes 4w..4w+3 little-endian at address 4w, only for complete words within eff_len
   task automatic plan_load(input logic [7:0] b[$], input int len);
      logic [31:0] w;
      exp_sum = 32'd0;
      for (int i = 0; i < eff_of(len); i++) begin
         if (4 * i + 3 < b.size()) begin
            w = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            exp_q.push_back('{addr: 32'(4 * i), data: w});
            exp_sum += w;
         end
      end
   endtask

   task automatic start_load(input int len);
      start_i = 1'b1;
      len_i   = 6'(len);
      tick();
      start_i = 1'b0;
      check("ready_after_start", 32'(byte_ready_o), 32'(eff_of(len) > 0));
      check("done_after_start", 32'(done_o), 32'(eff_of(len) == 0));
      check("checksum_cleared", checksum_o, 32'd0);
   endtask

   // mode 0: valid held, 1: valid toggles, 2: random gaps
   task automatic send(input logic [7:0] b[$], input int lo, input int hi, input int mode);
      for (int i = lo; i <= hi; i++) begin
         int gap;
         int budget;
         gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
         byte_valid_i = 1'b0;
         repeat (gap) tick();
         byte_valid_i = 1'b1;
         byte_i       = b[i];
         budget       = 0;
         forever begin
            @(negedge clk_i);
            if (byte_ready_o) break;
            budget++;
            if (budget > 200) break;
         end
         if (budget > 200) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: byte %0d not accepted, expected acceptance", i);
            byte_valid_i = 1'b0;
            return;
         end
         tick();
      end
      byte_valid_i = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300; i++) begin
         if (done_o) break;
         @(negedge clk_i);
      end
      check("done_reached", 32'(done_o), 32'd1);
      tick();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
      check({tag, "_wr_addr"}, wr_addr_o, 32'd0);
      check({tag, "_wr_data"}, wr_data_o, 32'd0);
      check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
      check({tag, "_done"}, 32'(done_o), 32'd0);
      check({tag, "_checksum"}, checksum_o, 32'd0);
      check({tag, "_hold"}, 32'(cpu_hold_o), 32'd1);
   endtask

   initial begin
      logic [7:0] prog[$];
      logic [7:0] ramp[$];
      logic [7:0] ff4[$];
      logic [7:0] rnd[$];
      int         w0;

      prog = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h01, 8'h00, 8'h00, 8'h00};
      ff4  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 160; i++) ramp.push_back(8'(i));

      rst_i = 1'b0; start_i = 1'b0; len_i = 6'd0; byte_valid_i = 1'b0; byte_i = 8'd0;
      tick(); tick();
      check_reset_state("reset");
      rst_i = 1'b1;
      tick();

      // Two-word program, valid held high
      w0 = writes;
      plan_load(prog, 2);
      start_load(2);
      send(prog, 0, 7, 0);
      check("t1_wr_cycle_strobe", 32'(wr_en_o), 32'd1);
      check("t1_wr_cycle_ready", 32'(byte_ready_o), 32'd0);
      check("t1_wr_cycle_done", 32'(done_o), 32'd0);
      tick();
      check("t1_done", 32'(done_o), 32'd1);
      check("t1_hold", 32'(cpu_hold_o), 32'd0);
      check("t1_checksum", checksum_o, 32'h2008_0014);
      check("t1_model_sum", checksum_o, exp_sum);
      check("t1_writes", 32'(writes - w0), 32'd2);

      // Same program from DONE, valid toggling
      w0 = writes;
      plan_load(prog, 2);
      start_load(2);
      check("t2_hold_on_restart", 32'(cpu_hold_o), 32'd1);
      send(prog, 0, 7, 1);
      wait_done();
      check("t2_checksum", checksum_o, 32'h2008_0014);
      check("t2_writes", 32'(writes - w0), 32'd2);
      check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

      // Over-length request clamps to 32 words
      w0 = writes;
      plan_load(ramp, 40);
      start_load(40);
      send(ramp, 0, 127, 0);
      byte_valid_i = 1'b1;
      byte_i       = ramp[128];
      repeat (6) begin
         @(negedge clk_i);
         check("t3_no_extra_ready", 32'(byte_ready_o), 32'd0);
      end
      tick();
      byte_valid_i = 1'b0;
      wait_done();
      check("t3_writes", 32'(writes - w0), 32'd32);
      check("t3_last_addr", wr_addr_o, 32'h0000_007C);
      check("t3_checksum", checksum_o, exp_sum);
      check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // Single FF word from DONE, with an ignored start pulse mid-load
      w0 = writes;
      plan_load(ff4, 1);
      start_load(1);
      send(ff4, 0, 1, 0);
      start_i = 1'b1;
      len_i   = 6'd5;
      tick();
      start_i = 1'b0;
      check("t4_mid_done", 32'(done_o), 32'd0);
      check("t4_mid_ready", 32'(byte_ready_o), 32'd1);
      send(ff4, 2, 3, 0);
      wait_done();
      repeat (5) tick();
      check("t4_checksum", checksum_o, 32'hFFFF_FFFF);
      check("t4_writes", 32'(writes - w0), 32'd1);
      check("t4_done_hold", 32'(done_o), 32'd1);

      // Reset mid-load after 6 bytes of a 3-word load
      w0 = writes;
      plan_load(ramp, 3);
      exp_q.delete();
      rnd = '{ramp[0], ramp[1], ramp[2], ramp[3], ramp[4], ramp[5]};
      plan_load(rnd, 3);
      start_load(3);
      send(rnd, 0, 5, 0);
      rst_i = 1'b0;
      #1;
      check_reset_state("midrst");
      check("midrst_writes", 32'(writes - w0), 32'd1);
      check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
      tick(); tick();
      rst_i = 1'b1;
      tick();
      check("midrst_no_late_write", 32'(writes - w0), 32'd1);

      // Zero length from IDLE, then a fresh one-word load
      plan_load(prog, 0);
      start_load(0);
      check("len0_hold", 32'(cpu_hold_o), 32'd0);
      check("len0_ready", 32'(byte_ready_o), 32'd0);
      w0 = writes;
      plan_load(prog, 1);
      start_load(1);
      send(prog, 0, 3, 0);
      wait_done();
      check("fresh_writes", 32'(writes - w0), 32'd1);
      check("fresh_checksum", checksum_o, 32'h2008_0013);

      // Randomized loads
      for (int k = 0; k < 6; k++) begin
         int len;
         len = int'($urandom_range(0, 40));
         rnd.delete();
         for (int i = 0; i < 4 * eff_of(len); i++) rnd.push_back(8'($urandom));
         w0 = writes;
         plan_load(rnd, len);
         start_load(len);
         if (rnd.size() > 0) send(rnd, 0, rnd.size() - 1, 2);
         wait_done();
         check("rnd_checksum", checksum_o, exp_sum);
         check("rnd_writes", 32'(writes - w0), 32'(eff_of(len)));
         check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
      end

      // Zero length from DONE clears the previous checksum
      plan_load(prog, 2);
      start_load(2);
      send(prog, 0, 7, 2);
      wait_done();
      w0 = writes;
      plan_load(prog, 0);
      start_load(0);
      repeat (4) tick();
      check("len0_done_writes", 32'(writes - w0), 32'd0);
      check("len0_done_checksum", checksum_o, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
